reg_bank_reader: RTL

//  32x32-bit MIPS general-purpose register bank with one write port and two

---
 rtl/reg_bank_reader_if.sv | 30 +++
 rtl/reg_bank_reader.sv | 100 ++++++++++
 2 files changed

// File: rtl/reg_bank_reader_if.sv
// Register bank access bus.
// Carries the write port (RegWrite/WriteReg/WriteData), the two read
// indices with their capture strobe (ReadReg1/ReadReg2/LoadAB), and the
// registered operand outputs (ReadData1/ReadData2/ABValid).
//   master : the decode side. It drives the indices and the write port,
//            and it receives the operand latches.
//   slave  : the register bank itself.
interface reg_bank_reader_if #(
  parameter int DATA_W = 32
);
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic              LoadAB;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ABValid;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadAB,
    input  ReadData1, ReadData2, ABValid
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadAB,
    output ReadData1, ReadData2, ABValid
  );
endinterface

// File: rtl/reg_bank_reader.sv
// 32 x DATA_W MIPS general-purpose register bank.
// The bank has one write port and two read ports. Each read port is
// captured into an A/B operand latch.
// Ports:
//   clk    : system clock. All state updates on the rising edge.
//   reset  : asynchronous, active low. Clears the bank, except that
//            reg[SP_IDX] is loaded with SP_RESET. Also clears the latches
//            and ABValid.
//   bus    : reg_bank_reader_if.slave, which carries:
//            - the write port
//            - the read indices and the LoadAB strobe
//            - the A/B latches and ABValid
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no capture since reset; A/B hold reset zeros, ABValid = 0
// LOADED | at least one LoadAB since reset; ABValid = 1 (sticky)
module reg_bank_reader #(
  parameter int DATA_W   = 32,
  parameter int SP_IDX   = 29,
  parameter int SP_RESET = 227
) (
  input logic              clk,
  input logic              reset,
  reg_bank_reader_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOADED = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic              wr_en;

  // Index 0 is hard-wired to zero, so a write aimed at it never takes effect.
  assign wr_en = bus.RegWrite && (bus.WriteReg != 5'd0);

  // A write and a read of the same register can land on one edge.
  // In that case the read port returns the incoming data, so the
  // latch never captures the stale value.
  always_comb begin
    rd_a = '0;
    if (bus.ReadReg1 != 5'd0) begin
      if (wr_en && (bus.WriteReg == bus.ReadReg1)) rd_a = bus.WriteData;
      else                                         rd_a = regs[bus.ReadReg1];
    end
  end

  always_comb begin
    rd_b = '0;
    if (bus.ReadReg2 != 5'd0) begin
      if (wr_en && (bus.WriteReg == bus.ReadReg2)) rd_b = bus.WriteData;
      else                                         rd_b = regs[bus.ReadReg2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_en) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_a <= '0;
      lat_b <= '0;
    end else if (bus.LoadAB) begin
      lat_a <= rd_a;
      lat_b <= rd_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.LoadAB) state_next = LOADED;
      LOADED:  state_next = LOADED;
      default: state_next = IDLE;
    endcase
  end

  assign bus.ReadData1 = lat_a;
  assign bus.ReadData2 = lat_b;
  assign bus.ABValid   = (state == LOADED);

endmodule
